mem_arbiter: RTL and testbench

Two-port arbiter and sequencer sharing the single uncached `Main_Memory` between the instruction-fetch path (port A, read-only) and the load/store path (port B, read/write). It latches one request at a time, drives the memory's level-sensitive `read`/`write` strobes until `Done`, and returns data plus a one-cycle completion pulse to the owning requester. Round-robin fairness applies when both ports request together. A watchdog aborts any transaction whose `Done` never arrives.

---
 rtl/mem_pkg.sv | 17 +
 rtl/rr_pick2.sv | 23 ++
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter slice: bus widths, FSM encoding and
// port-owner identifiers.
package mem_pkg;

   localparam int unsigned ADDR_W = 13;
   localparam int unsigned DATA_W = 13;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StResp = 2'd2
   } state_e;

   localparam logic OWN_A = 1'b0;
   localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to the
// port that did not own the previous transaction.
module rr_pick2
   import mem_pkg::*;
(
   input  logic req_a,
   input  logic req_b,
   input  logic last_owner,
   output logic grant_valid,
   output logic grant_owner
);

   always_comb begin
      grant_valid = req_a | req_b;
      grant_owner = OWN_A;
      if (req_a && req_b) begin
         grant_owner = ~last_owner;
      end else if (req_b) begin
         grant_owner = OWN_B;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port sequencer for the shared Main_Memory: latches one request, holds the
// memory strobe until Done or watchdog expiry, then pulses completion to the owner.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_req,
   input  logic [ADDR_W-1:0] a_addr,
   output logic [DATA_W-1:0] a_rdata,
   output logic              a_done,
   output logic              a_err,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic [DATA_W-1:0] b_rdata,
   output logic              b_done,
   output logic              b_err,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_dataIn,
   input  logic [DATA_W-1:0] mem_dataOut,
   output logic              mem_write,
   output logic              mem_read,
   input  logic              mem_done
);

   localparam logic [7:0] WdLast = 8'(TIMEOUT - 1);

   state_e            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_owner_q, last_owner_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [7:0]        wd_cnt_q, wd_cnt_d;

   logic grant_valid;
   logic grant_owner;

   rr_pick2 u_pick (
      .req_a       (a_req),
      .req_b       (b_req),
      .last_owner  (last_owner_q),
      .grant_valid (grant_valid),
      .grant_owner (grant_owner)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= StIdle;
         owner_q      <= OWN_A;
         last_owner_q <= OWN_B;
         addr_q       <= '0;
         we_q         <= 1'b0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
         wd_cnt_q     <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         addr_q       <= addr_d;
         we_q         <= we_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
         wd_cnt_q     <= wd_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      addr_d       = addr_q;
      we_d         = we_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      wd_cnt_d     = wd_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (grant_valid) begin
               state_d  = StBusy;
               owner_d  = grant_owner;
               addr_d   = (grant_owner == OWN_B) ? b_addr : a_addr;
               we_d     = (grant_owner == OWN_B) && b_we;
               wdata_d  = (grant_owner == OWN_B) ? b_wdata : '0;
               rdata_d  = '0;
               err_d    = 1'b0;
               wd_cnt_d = '0;
            end
         end
         StBusy: begin
            wd_cnt_d = wd_cnt_q + 8'd1;
            // Done on the expiry cycle still counts as success.
            if (mem_done) begin
               rdata_d = we_q ? '0 : mem_dataOut;
               state_d = StResp;
            end else if (wd_cnt_q == WdLast) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = StResp;
            end
         end
         StResp: begin
            last_owner_d = owner_q;
            state_d      = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      mem_address = addr_q;
      mem_dataIn  = wdata_q;
      mem_read    = (state_q == StBusy) && !we_q;
      mem_write   = (state_q == StBusy) && we_q;
      a_done      = (state_q == StResp) && (owner_q == OWN_A);
      b_done      = (state_q == StResp) && (owner_q == OWN_B);
      a_err       = a_done && err_q;
      b_err       = b_done && err_q;
      a_rdata     = a_done ? rdata_q : '0;
      b_rdata     = b_done ? rdata_q : '0;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cycle table for the corner cases, then random
// traffic against a transaction-level timing/data model with a behavioural memory.
module tb_mem_arbiter;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        a_req, b_req, b_we;
   logic [12:0] a_addr, b_addr, b_wdata;
   logic [12:0] a_rdata, b_rdata;
   logic        a_done, a_err, b_done, b_err;
   logic [12:0] mem_address, mem_dataIn, mem_dataOut;
   logic        mem_write, mem_read, mem_done;

   always #5 clk = ~clk;

   mem_arbiter #(.TIMEOUT(T)) dut (
      .clk         (clk),
      .reset       (reset),
      .a_req       (a_req),
      .a_addr      (a_addr),
      .a_rdata     (a_rdata),
      .a_done      (a_done),
      .a_err       (a_err),
      .b_req       (b_req),
      .b_we        (b_we),
      .b_addr      (b_addr),
      .b_wdata     (b_wdata),
      .b_rdata     (b_rdata),
      .b_done      (b_done),
      .b_err       (b_err),
      .mem_address (mem_address),
      .mem_dataIn  (mem_dataIn),
      .mem_dataOut (mem_dataOut),
      .mem_write   (mem_write),
      .mem_read    (mem_read),
      .mem_done    (mem_done)
   );

   typedef struct {
      logic        rst, areq;
      logic [12:0] aaddr;
      logic        breq, bwe;
      logic [12:0] baddr, bwdata;
      logic        mdone;
      logic [12:0] mdout;
      logic        erd, ewr;
      logic [12:0] eaddr, edin;
      logic        ead, eae;
      logic [12:0] eard;
      logic        ebd, ebe;
      logic [12:0] ebrd;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   failures = 0;

   logic [12:0] env_mem [0:8191];
   logic [12:0] ref_mem [0:8191];

   function automatic vec_t mk(input int rst, areq, aaddr, breq, bwe, baddr, bwdata, mdone,
                               mdout, erd, ewr, eaddr, edin, ead, eae, eard, ebd, ebe, ebrd);
      vec_t v;
      v.rst = rst[0];   v.areq = areq[0];   v.aaddr = aaddr[12:0];
      v.breq = breq[0]; v.bwe = bwe[0];     v.baddr = baddr[12:0];
      v.bwdata = bwdata[12:0]; v.mdone = mdone[0]; v.mdout = mdout[12:0];
      v.erd = erd[0];   v.ewr = ewr[0];     v.eaddr = eaddr[12:0];
      v.edin = edin[12:0]; v.ead = ead[0];  v.eae = eae[0];
      v.eard = eard[12:0]; v.ebd = ebd[0];  v.ebe = ebe[0];
      v.ebrd = ebrd[12:0];
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [12:0] act,
                      input logic [12:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0d: actual=%h expected=%h", nm, idx, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int     cyc, g, k, lat, idle_from;
   bit     m_active, m_owner, m_last, m_we, m_err, in_busy, in_resp, just_a, just_b;
   logic [12:0] m_addr, m_wdata, m_rdata;

   initial begin
      reset = 1'b0; a_req = 1'b0; b_req = 1'b0; b_we = 1'b0;
      a_addr = '0; b_addr = '0; b_wdata = '0; mem_done = 1'b0; mem_dataOut = '0;

      // inputs: rst areq aaddr breq bwe baddr bwdata mdone mdout
      // expect: rd wr addr din ad ae ard bd be brd
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,                 0,0,0,0,0,0,0,0,0,0));
      tbl.push_back(mk(1,1,'h5,0,0,0,0,0,0,               0,0,0,0,0,0,0,0,0,0));
      tbl.push_back(mk(1,1,'h5,0,0,0,0,0,0,               1,0,'h5,0,0,0,0,0,0,0));
      tbl.push_back(mk(1,1,'h5,0,0,0,0,1,'h1abc,          1,0,'h5,0,0,0,0,0,0,0));
      tbl.push_back(mk(1,1,'h5,0,0,0,0,0,0,               0,0,'h5,0,1,0,'h1abc,0,0,0));
      tbl.push_back(mk(1,0,0,1,1,'ha,'h10f0,0,0,          0,0,'h5,0,0,0,0,0,0,0));
      tbl.push_back(mk(1,0,0,1,1,'ha,'h10f0,1,0,          0,1,'ha,'h10f0,0,0,0,0,0,0));
      tbl.push_back(mk(1,0,0,1,1,'ha,'h10f0,0,'h1fff,     0,0,'ha,'h10f0,0,0,0,1,0,0));
      tbl.push_back(mk(1,1,'ha,0,0,0,0,0,0,               0,0,'ha,'h10f0,0,0,0,0,0,0));
      tbl.push_back(mk(1,1,'ha,0,0,0,0,1,'h10f0,          1,0,'ha,0,0,0,0,0,0,0));
      tbl.push_back(mk(1,1,'ha,0,0,0,0,0,0,               0,0,'ha,0,1,0,'h10f0,0,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,                 0,0,'ha,0,0,0,0,0,0,0));
      tbl.push_back(mk(1,1,'h11,1,0,'h22,0,0,0,           0,0,0,0,0,0,0,0,0,0));
      tbl.push_back(mk(1,1,'h11,1,0,'h22,0,1,'h123,       1,0,'h11,0,0,0,0,0,0,0));
      tbl.push_back(mk(1,1,'h11,1,0,'h22,0,0,0,           0,0,'h11,0,1,0,'h123,0,0,0));
      tbl.push_back(mk(1,1,'h11,1,0,'h22,0,0,0,           0,0,'h11,0,0,0,0,0,0,0));
      tbl.push_back(mk(1,1,'h11,1,0,'h22,0,1,'h456,       1,0,'h22,0,0,0,0,0,0,0));
      tbl.push_back(mk(1,1,'h11,1,0,'h22,0,0,0,           0,0,'h22,0,0,0,0,1,0,'h456));
      tbl.push_back(mk(1,1,'h11,1,0,'h22,0,0,0,           0,0,'h22,0,0,0,0,0,0,0));
      tbl.push_back(mk(1,1,'h11,1,0,'h22,0,1,'h789,       1,0,'h11,0,0,0,0,0,0,0));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,                 0,0,'h11,0,1,0,'h789,0,0,0));
      tbl.push_back(mk(1,0,0,1,0,'h33,0,0,'h1fff,         0,0,'h11,0,0,0,0,0,0,0));
      for (int i = 0; i < T; i++)
         tbl.push_back(mk(1,0,0,1,0,'h33,0,0,'h1fff,      1,0,'h33,0,0,0,0,0,0,0));
      tbl.push_back(mk(1,0,0,1,0,'h33,0,0,'h1fff,         0,0,'h33,0,0,0,0,1,1,0));
      tbl.push_back(mk(1,1,'h44,0,0,0,0,0,0,              0,0,'h33,0,0,0,0,0,0,0));
      tbl.push_back(mk(1,1,'h44,0,0,0,0,1,'haaa,          1,0,'h44,0,0,0,0,0,0,0));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,                 0,0,'h44,0,1,0,'haaa,0,0,0));
      tbl.push_back(mk(1,0,0,0,0,0,0,1,'h1fff,            0,0,'h44,0,0,0,0,0,0,0));
      tbl.push_back(mk(1,1,'h55,0,0,0,0,0,0,              0,0,'h44,0,0,0,0,0,0,0));
      tbl.push_back(mk(0,1,'h55,1,0,'h66,0,0,0,           1,0,'h55,0,0,0,0,0,0,0));
      tbl.push_back(mk(1,1,'h55,1,0,'h66,0,0,0,           0,0,0,0,0,0,0,0,0,0));
      tbl.push_back(mk(1,1,'h55,1,0,'h66,0,1,'hbbb,       1,0,'h55,0,0,0,0,0,0,0));
      tbl.push_back(mk(1,0,0,1,0,'h66,0,0,0,              0,0,'h55,0,1,0,'hbbb,0,0,0));
      tbl.push_back(mk(1,0,0,1,0,'h3,0,0,0,               0,0,'h55,0,0,0,0,0,0,0));
      tbl.push_back(mk(1,0,0,1,0,'h4,0,0,0,               1,0,'h3,0,0,0,0,0,0,0));
      tbl.push_back(mk(1,0,0,1,0,'h4,0,1,'hccc,           1,0,'h3,0,0,0,0,0,0,0));
      tbl.push_back(mk(1,0,0,1,0,'h4,0,1,'h1fff,          0,0,'h3,0,0,0,0,1,0,'hccc));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,                 0,0,'h3,0,0,0,0,0,0,0));

      tick();
      tick();
      foreach (tbl[i]) begin
         reset = tbl[i].rst;   a_req = tbl[i].areq;  a_addr = tbl[i].aaddr;
         b_req = tbl[i].breq;  b_we = tbl[i].bwe;    b_addr = tbl[i].baddr;
         b_wdata = tbl[i].bwdata; mem_done = tbl[i].mdone; mem_dataOut = tbl[i].mdout;
         chk("vec_mem_read", i, mem_read, tbl[i].erd);
         chk("vec_mem_write", i, mem_write, tbl[i].ewr);
         chk("vec_mem_address", i, mem_address, tbl[i].eaddr);
         chk("vec_mem_dataIn", i, mem_dataIn, tbl[i].edin);
         chk("vec_a_done", i, a_done, tbl[i].ead);
         chk("vec_a_err", i, a_err, tbl[i].eae);
         chk("vec_a_rdata", i, a_rdata, tbl[i].eard);
         chk("vec_b_done", i, b_done, tbl[i].ebd);
         chk("vec_b_err", i, b_err, tbl[i].ebe);
         chk("vec_b_rdata", i, b_rdata, tbl[i].ebrd);
         tick();
      end

      // Random traffic: model predicts each transaction's cycle window and result.
      for (int i = 0; i < 8192; i++) begin
         env_mem[i] = 13'(i) ^ 13'h0a5a;
         ref_mem[i] = 13'(i) ^ 13'h0a5a;
      end
      reset = 1'b0; a_req = 1'b0; b_req = 1'b0; mem_done = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      cyc = 0; idle_from = 0; m_active = 1'b0; m_last = 1'b1;
      g = 0; k = 0; lat = 0; m_owner = 1'b0; m_we = 1'b0; m_err = 1'b0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;

      for (int n = 0; n < 3000; n++) begin
         tick();
         cyc++;
         in_busy = m_active && (cyc > g) && (cyc <= g + k);
         in_resp = m_active && (cyc == g + k + 1);
         chk("rnd_mem_read", cyc, mem_read, in_busy && !m_we);
         chk("rnd_mem_write", cyc, mem_write, in_busy && m_we);
         if (in_busy) begin
            chk("rnd_mem_address", cyc, mem_address, m_addr);
            chk("rnd_mem_dataIn", cyc, mem_dataIn, m_wdata);
         end
         chk("rnd_a_done", cyc, a_done, in_resp && !m_owner);
         chk("rnd_a_err", cyc, a_err, in_resp && !m_owner && m_err);
         chk("rnd_a_rdata", cyc, a_rdata, (in_resp && !m_owner) ? m_rdata : 13'h0);
         chk("rnd_b_done", cyc, b_done, in_resp && m_owner);
         chk("rnd_b_err", cyc, b_err, in_resp && m_owner && m_err);
         chk("rnd_b_rdata", cyc, b_rdata, (in_resp && m_owner) ? m_rdata : 13'h0);

         just_a = in_resp && !m_owner;
         just_b = in_resp && m_owner;
         if (in_resp) begin
            m_active = 1'b0;
            m_last = m_owner;
            idle_from = cyc + 1;
            if (m_owner) b_req = 1'b0;
            else a_req = 1'b0;
         end
         if (!a_req && !just_a && $urandom_range(2) == 0) begin
            a_req = 1'b1;
            a_addr = 13'($urandom_range(31));
         end
         if (!b_req && !just_b && $urandom_range(2) == 0) begin
            b_req = 1'b1;
            b_we = 1'($urandom_range(1));
            b_addr = 13'($urandom_range(31));
            b_wdata = 13'($urandom);
         end

         if (in_busy) mem_done = (cyc - g == lat);
         else mem_done = ($urandom_range(3) == 0);
         mem_dataOut = env_mem[mem_address];
         if (in_busy && mem_done && mem_write) env_mem[mem_address] = mem_dataIn;

         if (!m_active && cyc >= idle_from && (a_req || b_req)) begin
            m_owner = (a_req && b_req) ? !m_last : b_req;
            g = cyc;
            lat = $urandom_range(T + 2, 1);
            k = (lat <= T) ? lat : T;
            m_err = (lat > T);
            m_addr = m_owner ? b_addr : a_addr;
            m_we = m_owner && b_we;
            m_wdata = m_owner ? b_wdata : 13'h0;
            m_rdata = (m_we || m_err) ? 13'h0 : ref_mem[m_addr];
            if (m_we && !m_err) ref_mem[m_addr] = m_wdata;
            m_active = 1'b1;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
